// File: rtl/vga_pkg.sv
// Shared VGA timing constants and count type (800x600 @ 60 Hz, 40 MHz pixel clock).
// Downstream pixel stages import this package for the same defaults.
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;

    localparam int unsigned DEF_V_ACTIVE = 600;
    localparam int unsigned DEF_V_FP     = 1;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 23;

    localparam int unsigned FRAME_CNT_W  = 16;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with enable. count is registered; count_next and tc are the
// combinational next value and terminal-count strobe, so a parent can register
// decodes of count_next with zero skew relative to count.
module mod_counter
    import vga_pkg::*;
#(
    parameter int unsigned Width   = CNT_W,
    parameter int unsigned Modulus = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic [Width-1:0] count_next,
    output logic             tc
);

    localparam logic [Width-1:0] Last = Width'(Modulus - 1);

    logic [Width-1:0] count_q;

    assign count = count_q;

    // Next-count and terminal count: tc fires only on an enabled wrap edge.
    always_comb begin
        tc         = en && (count_q == Last);
        count_next = count_q;
        if (tc) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: horizontal/vertical counters plus registered sync,
// blanking and frame-start flags. Optional 16-bit frame counter output when
// VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   en,
    output logic [CNT_W-1:0]       hcount,
    output logic [CNT_W-1:0]       vcount,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblnk,
    output logic                   vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`else
    output logic                   frame_start
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t HBLNK_START = CNT_W'(H_ACTIVE);
    localparam cnt_t HSYNC_START = CNT_W'(H_ACTIVE + H_FP);
    localparam cnt_t HSYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VBLNK_START = CNT_W'(V_ACTIVE);
    localparam cnt_t VSYNC_START = CNT_W'(V_ACTIVE + V_FP);
    localparam cnt_t VSYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    cnt_t h_next, v_next;
    logic h_tc, v_tc;
    logic hsync_q, vsync_q, hblnk_q, vblnk_q, frame_start_q;

    mod_counter #(
        .Width   (CNT_W),
        .Modulus (H_TOTAL)
    ) u_hcnt (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .count      (hcount),
        .count_next (h_next),
        .tc         (h_tc)
    );

    // Vertical counter advances only on the horizontal wrap edge.
    mod_counter #(
        .Width   (CNT_W),
        .Modulus (V_TOTAL)
    ) u_vcnt (
        .pclk       (pclk),
        .rst        (rst),
        .en         (h_tc),
        .count      (vcount),
        .count_next (v_next),
        .tc         (v_tc)
    );

    // Flags decoded from next counts so they line up with the registered counts.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hblnk_q       <= (h_next >= HBLNK_START);
            hsync_q       <= (h_next >= HSYNC_START) && (h_next <= HSYNC_END);
            vblnk_q       <= (v_next >= VBLNK_START);
            vsync_q       <= (v_next >= VSYNC_START) && (v_next <= VSYNC_END);
            // v_tc implies an enabled edge wrapping both counters to (0,0).
            frame_start_q <= v_tc;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    // Frames seen since reset; wraps naturally at 2^16.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (frame_start_q) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
